// File: rtl/alu_issue.sv
// Issue stage for RV32I OP/OP-IMM: decodes, reads the register file, tracks pending
// destinations and presents a registered ALU request behind a valid/ready handshake.
module alu_issue #(
    parameter int REG_COUNT = 32,
    parameter bit CHECK_WAW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr,
    output logic        o_instr_ready,
    output logic        o_alu_valid,
    input  logic        i_alu_ready,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_op2,
    output logic [31:0] o_alu_x,
    output logic [31:0] o_alu_y,
    output logic [4:0]  o_alu_rd,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_illegal
);
    localparam int         IDX_W   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic in_range(input logic [4:0] idx);
        return {27'b0, idx} < 32'(REG_COUNT);
    endfunction

    logic [31:0]          regs [REG_COUNT];
    logic [REG_COUNT-1:0] pend;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    logic        legal;
    logic        is_op;
    logic        shift;
    logic        op2_d;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] y_d;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        hazard;
    logic        slot_free;
    logic        issue;
    logic        illegal_take;

    always_comb begin
        legal = 1'b0;
        is_op = 1'b0;
        op2_d = 1'b0;
        shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        case (opcode)
            OPC_OP: begin
                is_op = 1'b1;
                if (funct7 == F7_ZERO) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    op2_d = 1'b1;
                end
            end
            OPC_IMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == F7_ZERO);
                    3'b101: begin
                        legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        op2_d = (funct7 == F7_ALT);
                    end
                    default: legal = 1'b1;
                endcase
            end
            default: ;
        endcase
        // rs2 is only a register index for OP; for OP-IMM those bits are immediate
        if (!in_range(rd) || !in_range(rs1) || (is_op && !in_range(rs2))) begin
            legal = 1'b0;
        end
    end

    // Operand read with same-cycle writeback bypass; x0 always reads zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && in_range(rs1)) rs1_val = regs[rs1[IDX_W-1:0]];
        if (rs2 != 5'd0 && in_range(rs2)) rs2_val = regs[rs2[IDX_W-1:0]];
        if (rs1 != 5'd0 && i_wb_valid && i_wb_rd == rs1) rs1_val = i_wb_data;
        if (rs2 != 5'd0 && i_wb_valid && i_wb_rd == rs2) rs2_val = i_wb_data;
    end

    always_comb begin
        y_d = '0;
        if (is_op) y_d = shift ? {27'b0, rs2_val[4:0]} : rs2_val;
        else       y_d = shift ? {27'b0, rs2} : {{20{i_instr[31]}}, i_instr[31:20]};
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rd_busy  = 1'b0;
        if (in_range(rs1)) rs1_busy = pend[rs1[IDX_W-1:0]] && !(i_wb_valid && i_wb_rd == rs1);
        if (in_range(rs2)) rs2_busy = pend[rs2[IDX_W-1:0]] && !(i_wb_valid && i_wb_rd == rs2);
        if (in_range(rd))  rd_busy  = pend[rd[IDX_W-1:0]];
    end

    assign hazard        = rs1_busy || (is_op && rs2_busy) || (CHECK_WAW && rd_busy);
    assign slot_free     = !o_alu_valid || i_alu_ready;
    assign o_instr_ready = legal ? (slot_free && !hazard) : 1'b1;
    assign issue         = i_instr_valid && o_instr_ready && legal;
    assign illegal_take  = i_instr_valid && !legal;

    // Request register: loaded on issue, held while the ALU back-pressures
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_valid <= 1'b0;
            o_illegal   <= 1'b0;
            o_alu_op    <= '0;
            o_alu_op2   <= 1'b0;
            o_alu_x     <= '0;
            o_alu_y     <= '0;
            o_alu_rd    <= '0;
        end else begin
            o_illegal <= illegal_take;
            if (issue) begin
                o_alu_valid <= 1'b1;
                o_alu_op    <= funct3;
                o_alu_op2   <= op2_d;
                o_alu_x     <= rs1_val;
                o_alu_y     <= y_d;
                o_alu_rd    <= rd;
            end else if (i_alu_ready) begin
                o_alu_valid <= 1'b0;
            end
        end
    end

    // Register file and scoreboard; the later issue assignment makes set win over clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            pend <= '0;
        end else begin
            if (i_wb_valid && i_wb_rd != 5'd0 && in_range(i_wb_rd)) begin
                regs[i_wb_rd[IDX_W-1:0]] <= i_wb_data;
                pend[i_wb_rd[IDX_W-1:0]] <= 1'b0;
            end
            if (issue && rd != 5'd0) begin
                pend[rd[IDX_W-1:0]] <= 1'b1;
            end
        end
    end
endmodule
